rsa_cipher_serializer: RTL and testbench
========================================

# rsa_cipher_serializer

Downstream stage of the RSA encryptor. Captures the 256-bit ciphertext when the encryptor's done flag (`enc_flag`) rises, then streams it out as 32 bytes over a valid/ready byte interface toward the host link. It decouples the multi-cycle modular-exponentiation core from a byte-wide consumer, and it reports a ciphertext that arrives while a frame is still streaming.

## Interface
- `DATA_W`, 256: ciphertext width. Must be a multiple of `BYTE_W`.
- `BYTE_W`, 8: output byte width.
- `MSB_FIRST`, 1: 1 = send the most-significant byte first; 0 = send the least-significant byte first.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `new`  in  1: synchronous restart, the same pulse that restarts the encryptor.
- `done`  in  1: encryptor done level. Stays high until the next `new`.
- `data_in`  in  `DATA_W`: ciphertext. Valid whenever `done` is high.
- `tx_data`  out  `BYTE_W`: current output byte.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: consumer accepts the byte.
- `tx_last`  out  1: high together with the final byte of a frame.
- `busy`  out  1: a frame is in flight.
- `overrun`  out  1: sticky flag; a ciphertext was dropped.

## Operation
- **Capture event:** `cap = done & ~done_q`, where `done_q` is a registered copy of `done` (reset value 0).
- **States:** IDLE and SEND.
- **IDLE:**
  - On `cap`: load `shreg <= data_in`, `cnt <= 0`, go to SEND.
  - Otherwise stay in IDLE.
- **SEND:**
  - `tx_valid = 1`.
  - `tx_data = shreg[DATA_W-1 -: BYTE_W]` when `MSB_FIRST`, else `shreg[BYTE_W-1:0]`.
  - On handshake (`tx_valid & tx_ready`): shift `shreg` by `BYTE_W` toward the output end and increment `cnt`.
  - `tx_last = (cnt == DATA_W/BYTE_W - 1)`.
  - On the handshake of the last byte:
    - If `cap` is also high that cycle, the new ciphertext is accepted and the next frame starts immediately, with no bubble and no overrun.
    - Otherwise go to IDLE.
  - `cap` in SEND at any other time sets `overrun`, and the capture is discarded. The frame in flight is unaffected.
- **`new`** (priority over everything except `rst`):
  - State goes to IDLE, `cnt <= 0`, `done_q <= 0`, `overrun <= 0`.
  - A frame in flight is abandoned: `tx_valid` drops the next cycle even without a handshake. This is the only permitted withdrawal of `tx_valid`.
- **Handshake rules:**
  - While `tx_valid` is high, `tx_data` and `tx_last` are stable until the handshake.
  - `tx_ready` may toggle freely. `tx_valid` never depends combinationally on `tx_ready`.
- **`busy`** equals (state == SEND).
- **Widths:** `cnt` is `$clog2(DATA_W/BYTE_W)` bits wide. There is no wrap inside a frame because `cnt` is cleared at every capture.

## Timing
- **Reset values:** `tx_valid = 0`, `tx_last = 0`, `tx_data = 0`, `busy = 0`, `overrun = 0`, state IDLE, `shreg = 0`, `cnt = 0`, `done_q = 0`.
- **Latency:** `cap` sampled at edge k drives `tx_valid` high after edge k, i.e. visible in cycle k+1.
- **Throughput:** 1 byte/cycle with `tx_ready` held high. A frame takes 32 cycles minimum.
- **`done` high at reset release:** produces `cap` on the first active edge, so the frame is sent.
- **`done` held high across frames:** gives exactly one capture. A second frame needs `new` (or reset) followed by a fresh rising edge of `done`.
- **`rst` mid-frame:** outputs drop to their reset values immediately (asynchronous).
- **`new` with `cap` in the same cycle:** `new` wins and the capture is discarded. If `done` is still high after `new`, the next cycle re-detects the edge, because `done_q` was cleared.

## Structure
- **Shared package `rsa_pkg`:**
  - Constants `CIPHER_W=256`, `BYTE_W=8`, `NUM_BYTES=CIPHER_W/BYTE_W`.
  - `ser_state_t` enum {IDLE, SEND}.
  - The encryptor and decryptor output widths reference `CIPHER_W` from the same package.
- **Sub-module `rsa_rise_detect`:** `done_q` register with synchronous clear on `new`, producing `cap`. It is reused later for the decryptor's `dec_flag`.
- The rest stays flat in one module: FSM, shift register, counter, overrun flag.

## Test plan
- **Basic stream:** reset, then `done` rises with `data_in = 256'h0102…1F20` and `tx_ready = 1`. Required: 32 consecutive bytes 8'h01…8'h20, `tx_last` only on 8'h20, `busy` low the cycle after, `overrun = 0`.
- **Backpressure:** same data with `tx_ready` toggling 1/0 each cycle. Required: the same 32 bytes in order, `tx_data` stable while stalled, the frame takes 64 cycles.
- **Overrun:** start a frame, then after byte 10 pulse `new`-free `done` low→high. Required: `overrun = 1`, the current frame completes unchanged, no second frame.
- **Back-to-back:** `done` rises on the same cycle as the last-byte handshake, with a new `data_in = {32{8'hA5}}`. Required: the first A5 byte follows 8'h20 the next cycle with no bubble, `overrun = 0`.
- **Abort:** `new` asserted after byte 5. Required: `tx_valid = 0` next cycle, `overrun` cleared, a subsequent `done` rise streams a full frame from byte 0.
- **Asynchronous reset mid-frame and LSB-first:** `rst` asserted mid-frame gives all outputs 0 before the next clock edge. With `MSB_FIRST = 0`, `data_in = 256'h…1F20` sends 8'h20 first.

Source files
------------

// File: rtl/rsa_pkg.sv
// ----------------------------------------------------------------------------
// rsa_pkg
//   Shared constants and types for the RSA encryptor/decryptor datapath and
//   its host-side serializers.
//   CIPHER_W    : ciphertext width used by encryptor/decryptor outputs
//   BYTE_W      : host link byte width
//   NUM_BYTES   : bytes per ciphertext frame
//   ser_state_t : serializer FSM states
// ----------------------------------------------------------------------------
package rsa_pkg;

   localparam int unsigned CIPHER_W  = 256;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned NUM_BYTES = CIPHER_W / BYTE_W;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

endpackage : rsa_pkg

// File: rtl/rsa_rise_detect.sv
// ----------------------------------------------------------------------------
// rsa_rise_detect
//   Rising-edge detector for a core done level (enc_flag / dec_flag).
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   clr   : synchronous clear of the history bit (core restart pulse)
//   level : done level from the core
//   rise  : level is high now and was low (or cleared) on the previous edge
// ----------------------------------------------------------------------------
module rsa_rise_detect
   import rsa_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic level,
   output logic rise
);

   logic level_q;

   // Clearing the history on restart lets a level that is still high be
   // detected again on the following edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= 1'b0;
      end else if (clr) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign rise = level & ~level_q;

endmodule : rsa_rise_detect

// File: rtl/rsa_cipher_serializer.sv
// ----------------------------------------------------------------------------
// rsa_cipher_serializer
//   Captures the encryptor ciphertext on the rising edge of its done level
//   and streams it out as DATA_W/BYTE_W bytes over a valid/ready interface.
//   A ciphertext arriving mid-frame is dropped and flagged on overrun.
//
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   restart  : synchronous restart (the encryptor's "new" pulse); abandons
//              any frame in flight and clears overrun
//   done     : encryptor done level, high until the next restart
//   data_in  : ciphertext, valid while done is high
//   tx_data  : current output byte
//   tx_valid : tx_data is valid
//   tx_ready : consumer accepts the byte
//   tx_last  : high with the final byte of a frame
//   busy     : a frame is in flight
//   overrun  : sticky, a ciphertext was dropped
// ----------------------------------------------------------------------------
module rsa_cipher_serializer
   import rsa_pkg::*;
#(
   parameter int unsigned DATA_W    = CIPHER_W,
   parameter int unsigned BYTE_W    = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              done,
   input  logic [DATA_W-1:0] data_in,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_last,
   output logic              busy,
   output logic              overrun
);

   localparam int unsigned     NUM_B    = DATA_W / BYTE_W;
   localparam int unsigned     CNT_W    = (NUM_B > 1) ? $clog2(NUM_B) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_B - 1);

   ser_state_t        state;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shifted;
   logic [CNT_W-1:0]  cnt;
   logic              cap;
   logic              hs;

   rsa_rise_detect u_done_rise (
      .clk   (clk),
      .rst   (rst),
      .clr   (restart),
      .level (done),
      .rise  (cap)
   );

   // Bytes leave from one end of the shift register; zeros fill the other.
   generate
      if (MSB_FIRST) begin : g_msb
         assign tx_data = shreg[DATA_W-1 -: BYTE_W];
         assign shifted = {shreg[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      end else begin : g_lsb
         assign tx_data = shreg[BYTE_W-1:0];
         assign shifted = {{BYTE_W{1'b0}}, shreg[DATA_W-1:BYTE_W]};
      end
   endgenerate

   assign tx_valid = (state == SEND);
   assign busy     = (state == SEND);
   assign hs       = tx_valid & tx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         tx_last <= 1'b0;
         overrun <= 1'b0;
      end else if (restart) begin
         state   <= IDLE;
         cnt     <= '0;
         tx_last <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cap) begin
                  state   <= SEND;
                  shreg   <= data_in;
                  cnt     <= '0;
                  tx_last <= (NUM_B == 1);
               end
            end
            SEND: begin
               if (hs && (cnt == LAST_IDX)) begin
                  // A capture coinciding with the last handshake chains
                  // straight into the next frame instead of overrunning.
                  if (cap) begin
                     shreg   <= data_in;
                     cnt     <= '0;
                     tx_last <= (NUM_B == 1);
                  end else begin
                     state   <= IDLE;
                     shreg   <= shifted;
                     cnt     <= '0;
                     tx_last <= 1'b0;
                  end
               end else begin
                  if (hs) begin
                     shreg   <= shifted;
                     cnt     <= cnt + CNT_W'(1);
                     tx_last <= ((cnt + CNT_W'(1)) == LAST_IDX);
                  end
                  if (cap) begin
                     overrun <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : rsa_cipher_serializer

// File: tb/tb_rsa_cipher_serializer.sv
// ----------------------------------------------------------------------------
// tb_rsa_cipher_serializer
//   Directed and randomized checks of the ciphertext serializer. Two
//   instances share all inputs: one MSB-first, one LSB-first. Expected bytes
//   are taken straight from the captured ciphertext by byte index.
// ----------------------------------------------------------------------------
module tb_rsa_cipher_serializer;

   localparam int unsigned DW = 256;
   localparam int unsigned NB = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          restart;
   logic          done;
   logic [DW-1:0] data_in;
   logic          tx_ready;

   logic [7:0] m_data, l_data;
   logic       m_valid, l_valid, m_last, l_last, m_busy, l_busy, m_ovr, l_ovr;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [DW-1:0] D_SEQ =
      256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
   localparam logic [DW-1:0] D_A5 = {32{8'hA5}};

   rsa_cipher_serializer #(.DATA_W(DW), .BYTE_W(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .restart(restart), .done(done), .data_in(data_in),
      .tx_data(m_data), .tx_valid(m_valid), .tx_ready(tx_ready),
      .tx_last(m_last), .busy(m_busy), .overrun(m_ovr)
   );

   rsa_cipher_serializer #(.DATA_W(DW), .BYTE_W(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .restart(restart), .done(done), .data_in(data_in),
      .tx_data(l_data), .tx_valid(l_valid), .tx_ready(tx_ready),
      .tx_last(l_last), .busy(l_busy), .overrun(l_ovr)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand256();
      logic [DW-1:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Byte i of a frame, as the consumer should see it.
   function automatic logic [7:0] msb_byte(input logic [DW-1:0] d, input int i);
      return d[DW-8-8*i +: 8];
   endfunction
   function automatic logic [7:0] lsb_byte(input logic [DW-1:0] d, input int i);
      return d[8*i +: 8];
   endfunction

   task automatic chk_idle_both(input string tag, input logic exp_ovr);
      chk({tag, "_valid_m"}, m_valid, 1'b0);
      chk({tag, "_valid_l"}, l_valid, 1'b0);
      chk({tag, "_busy"},    m_busy,  1'b0);
      chk({tag, "_last"},    m_last,  1'b0);
      chk({tag, "_ovr_m"},   m_ovr,   exp_ovr);
      chk({tag, "_ovr_l"},   l_ovr,   exp_ovr);
   endtask

   // Raise done with fresh data; the frame is visible at the next negedge.
   task automatic start(input logic [DW-1:0] d);
      done    = 1'b1;
      data_in = d;
      @(negedge clk);
   endtask

   // Consume nbytes of frame d. mode 0: ready high, 1: toggle starting low,
   // 2: random. done is dropped at cycle lo_at and raised (with hi_data) at
   // cycle hi_at, counted from the first cycle of the call.
   task automatic consume(input string tag, input logic [DW-1:0] d,
                          input int mode, input int nbytes,
                          input int lo_at, input int hi_at,
                          input logic [DW-1:0] hi_data, output int cycles);
      int   idx;
      logic r;
      idx    = 0;
      cycles = 0;
      while (idx < nbytes && cycles < 300) begin
         chk({tag, "_valid"}, m_valid, 1'b1);
         chk({tag, "_busy"},  m_busy,  1'b1);
         chk({tag, "_data_m"}, m_data, msb_byte(d, idx));
         chk({tag, "_data_l"}, l_data, lsb_byte(d, idx));
         chk({tag, "_last_m"}, m_last, (idx == NB - 1));
         chk({tag, "_last_l"}, l_last, (idx == NB - 1));
         if (cycles == lo_at) done = 1'b0;
         if (cycles == hi_at) begin
            done    = 1'b1;
            data_in = hi_data;
         end
         case (mode)
            0:       r = 1'b1;
            1:       r = cycles[0];
            default: r = (($urandom % 4) != 0);
         endcase
         tx_ready = r;
         @(negedge clk);
         cycles++;
         if (r) idx++;
      end
      if (idx < nbytes) chk({tag, "_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic do_restart();
      restart  = 1'b1;
      done     = 1'b0;
      tx_ready = 1'b0;
      @(negedge clk);
      restart = 1'b0;
      chk_idle_both("restart", 1'b0);
   endtask

   initial begin
      int            cyc;
      logic [DW-1:0] d2, d3;

      rst      = 1'b1;
      restart  = 1'b0;
      done     = 1'b0;
      data_in  = '0;
      tx_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      chk_idle_both("reset", 1'b0);
      chk("reset_data_m", m_data, 8'h00);
      chk("reset_data_l", l_data, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      chk_idle_both("post_reset", 1'b0);

      // Basic stream, one byte per cycle
      start(D_SEQ);
      consume("basic", D_SEQ, 0, NB, -1, -1, D_SEQ, cyc);
      chk("basic_cycles", cyc, 32);
      chk_idle_both("basic_end", 1'b0);
      repeat (3) @(negedge clk);
      chk_idle_both("basic_no_refire", 1'b0);

      // Backpressure: ready toggles, frame takes twice as long
      do_restart();
      start(D_SEQ);
      consume("bp", D_SEQ, 1, NB, -1, -1, D_SEQ, cyc);
      chk("bp_cycles", cyc, 64);
      chk_idle_both("bp_end", 1'b0);

      // Overrun: done re-rises mid-frame, frame unaffected, no second frame
      do_restart();
      start(D_SEQ);
      consume("ovr", D_SEQ, 0, NB, 11, 12, D_A5, cyc);
      chk_idle_both("ovr_end", 1'b1);
      repeat (3) @(negedge clk);
      chk_idle_both("ovr_no_frame", 1'b1);

      // Back-to-back: done rises with the last-byte handshake
      do_restart();
      start(D_SEQ);
      consume("b2b_a", D_SEQ, 0, NB, 5, 31, D_A5, cyc);
      chk("b2b_ovr_mid", m_ovr, 1'b0);
      consume("b2b_b", D_A5, 0, NB, -1, -1, D_A5, cyc);
      chk("b2b_b_cycles", cyc, 32);
      chk_idle_both("b2b_end", 1'b0);

      // Abort: restart after byte 5 while done stays high
      do_restart();
      d2 = rand256();
      d3 = rand256();
      start(d2);
      consume("abort_a", d2, 0, 5, 2, 3, d2, cyc);
      chk("abort_ovr_set", m_ovr, 1'b1);
      chk("abort_valid_before", m_valid, 1'b1);
      chk("abort_byte5", m_data, msb_byte(d2, 5));
      restart  = 1'b1;
      tx_ready = 1'b0;
      data_in  = d3;
      @(negedge clk);
      chk_idle_both("abort", 1'b0);
      restart = 1'b0;
      @(negedge clk);
      consume("abort_b", d3, 2, NB, -1, -1, d3, cyc);
      chk_idle_both("abort_b_end", 1'b0);

      // Restart coinciding with a done rise: restart wins, edge re-detected
      for (int k = 0; k < 3; k++) begin
         do_restart();
         d2       = rand256();
         done     = 1'b1;
         data_in  = d2;
         restart  = 1'b1;
         @(negedge clk);
         chk_idle_both("new_cap", 1'b0);
         restart = 1'b0;
         @(negedge clk);
         consume("rand", d2, 2, NB, -1, -1, d2, cyc);
         chk_idle_both("rand_end", 1'b0);
      end

      // Asynchronous reset mid-frame, then done high at reset release
      do_restart();
      d3 = rand256();
      start(d3);
      consume("arst_a", d3, 0, 7, -1, -1, d3, cyc);
      #2 rst = 1'b1;
      #1;
      chk_idle_both("arst", 1'b0);
      chk("arst_data_m", m_data, 8'h00);
      chk("arst_data_l", l_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      consume("arst_b", d3, 0, NB, -1, -1, d3, cyc);
      chk_idle_both("arst_b_end", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule : tb_rsa_cipher_serializer
